tech_cg_ctrl: RTL

Multi-channel clock-gating controller. Produces NUM_CH gated clocks from one root clock and gates each channel automatically after a programmable idle period. Gating is preceded by a quiesce request/acknowledge handshake with the clocked block, and un-gating is followed by a settling window. It sits between the SoC clock root and the per-subsystem clock domains. Software can pin any channel on.

---
 rtl/tech_cg_ctrl_pkg.sv | 26 ++
 rtl/tech_cg.sv | 23 ++
 rtl/tech_cg_ctrl_ch.sv | 104 ++++++++++
 rtl/tech_cg_ctrl.sv | 60 ++++++
 4 files changed

// File: rtl/tech_cg_ctrl_pkg.sv
// ============================================================================
// tech_cg_ctrl_pkg : shared types and elaboration helpers for tech_cg_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package tech_cg_ctrl_pkg;

  typedef enum logic [1:0] {
    ON      = 2'd0,
    REQ_OFF = 2'd1,
    OFF     = 2'd2,
    WAKE    = 2'd3
  } cg_state_e;

  function automatic bit wake_cycles_ok(input int unsigned n);
    return (n >= 1);
  endfunction

  function automatic int unsigned wake_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tech_cg.sv
// ============================================================================
// tech_cg : latch-based clock gate cell (enable captured while clock is low)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tech_cg (
  input  logic clk_i,
  input  logic en_i,
  output logic clk_o
);

  logic en_l;

  always_latch begin
    if (!clk_i) en_l = en_i;
  end

  assign clk_o = clk_i & en_l;

endmodule

`default_nettype wire

// File: rtl/tech_cg_ctrl_ch.sv
// ============================================================================
// tech_cg_ctrl_ch : one gating channel - idle counter, quiesce handshake, wake
// Revision: 1.0
// ============================================================================
`default_nettype none

module tech_cg_ctrl_ch
  import tech_cg_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_W      = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              force_on_i,
  input  logic              auto_en_i,
  input  logic [IDLE_W-1:0] idle_thr_i,
  input  logic              activity_i,
  input  logic              off_ack_i,
  output logic              gate_en_o,
  output logic              off_req_o,
  output logic              ch_on_o,
  output logic              ch_ready_o
);

  localparam int unsigned WCW = wake_cnt_w(WAKE_CYCLES);
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);

  cg_state_e         state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WCW-1:0]    wake_cnt_q, wake_cnt_d;
  logic              en_q, en_d;
  logic              hold;

  assign hold = activity_i | force_on_i | ~auto_en_i | (idle_thr_i == '0);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ON: begin
        if (hold) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == idle_thr_i - IDLE_W'(1)) begin
          state_d    = REQ_OFF;
          idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      REQ_OFF: begin
        // Renewed demand aborts the request even if the ack arrives together.
        if (hold) begin
          state_d    = ON;
          idle_cnt_d = '0;
        end else if (off_ack_i) begin
          state_d = OFF;
        end
      end
      OFF: begin
        if (hold) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ON;
          idle_cnt_d = '0;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WCW'(1);
        end
      end
      default: state_d = ON;
    endcase
  end

  // Enable registered from the next state so it tracks state_q exactly.
  assign en_d = (state_d != OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ON;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      en_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      en_q       <= en_d;
    end
  end

  assign gate_en_o  = en_q;
  assign ch_on_o    = en_q;
  assign off_req_o  = (state_q == REQ_OFF);
  assign ch_ready_o = (state_q == ON) || (state_q == REQ_OFF);

endmodule

`default_nettype wire

// File: rtl/tech_cg_ctrl.sv
// ============================================================================
// tech_cg_ctrl : multi-channel auto idle clock-gating controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tech_cg_ctrl
  import tech_cg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned IDLE_W      = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] force_on_i,
  input  logic [NUM_CH-1:0] auto_en_i,
  input  logic [IDLE_W-1:0] idle_thr_i,
  input  logic [NUM_CH-1:0] activity_i,
  input  logic [NUM_CH-1:0] off_ack_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] off_req_o,
  output logic [NUM_CH-1:0] ch_on_o,
  output logic [NUM_CH-1:0] ch_ready_o
);

  if (!wake_cycles_ok(WAKE_CYCLES)) begin : g_bad_wake_cycles
    $error("tech_cg_ctrl: WAKE_CYCLES must be >= 1");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic gate_en;

    tech_cg_ctrl_ch #(
      .IDLE_W      (IDLE_W),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .force_on_i (force_on_i[g]),
      .auto_en_i  (auto_en_i[g]),
      .idle_thr_i (idle_thr_i),
      .activity_i (activity_i[g]),
      .off_ack_i  (off_ack_i[g]),
      .gate_en_o  (gate_en),
      .off_req_o  (off_req_o[g]),
      .ch_on_o    (ch_on_o[g]),
      .ch_ready_o (ch_ready_o[g])
    );

    tech_cg u_cg (
      .clk_i (clk),
      .en_i  (gate_en),
      .clk_o (clk_o[g])
    );
  end

endmodule

`default_nettype wire
